ddr_cmd_scheduler: RTL and testbench

Host-side command scheduler for the DDR4 controller. It sits between the host request port (`request`, `phy_addr`) and the downstream command engine. It queues read, write and mode-register requests in a small FIFO and issues them in order over a valid/ready handshake. Between column commands it enforces tCCD and read/write turnaround gaps derived from the live CL/CWL/BL settings, and it quiesces the bus around MRS updates.

---
 rtl/ddr_cmd_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_scheduler.sv
// DDR4 host command scheduler: in-order request FIFO with column gap,
// read/write turnaround and MRS quiesce enforcement.
module ddr_cmd_scheduler #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int T_WTR  = 4,
   parameter int T_MOD  = 24
) (
   input  logic                   CK_t,
   input  logic                   reset_n,
   input  logic [2:0]             request,
   input  logic [ADDR_W-1:0]      phy_addr,
   output logic                   req_rdy,
   input  logic [2:0]             CL,
   input  logic [2:0]             CWL,
   input  logic [2:0]             BL,
   input  logic [2:0]             tCCD,
   input  logic                   busy,
   output logic                   cmd_valid,
   output logic [1:0]             cmd_type,
   output logic [ADDR_W-1:0]      cmd_addr,
   input  logic                   cmd_rdy,
   output logic                   mrs_update,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int MW = $clog2(T_MOD + 2);

   localparam logic [1:0] RD  = 2'd1;
   localparam logic [1:0] WR  = 2'd2;
   localparam logic [1:0] MRS = 2'd3;

   typedef enum logic [2:0] {IDLE, WAIT, OFFER, QUIET, TMOD} state_t;

   state_t            state;
   logic [1:0]        type_mem [DEPTH];
   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr, nx_ptr;
   logic [4:0]        quiet, el, g_rd_q, g_wr_q, g_head, g_next, burst;
   logic [MW-1:0]     tmod_cnt;
   logic              col_seen, push, hs, full;
   logic              head_vld, nxt_vld, gap_ok;
   logic [1:0]        head_type, nxt_type;

   // Required spacing from previous column command to the next one.
   function automatic logic [4:0] gap_of(
      input logic       p_wr,
      input logic       n_wr,
      input logic [2:0] f_tccd,
      input logic [2:0] f_bl,
      input logic [2:0] f_cl,
      input logic [2:0] f_cwl
   );
      logic signed [4:0] t, b, raw;
      t = (f_tccd == 3'd0) ? 5'sd1 : $signed({2'b00, f_tccd});
      b = (f_bl == 3'd0) ? 5'sd4 : 5'sd2;
      if (p_wr == n_wr)
         raw = t;
      else if (p_wr)
         raw = $signed({2'b00, f_cwl}) + b + $signed(5'(T_WTR));
      else
         raw = $signed({2'b00, f_cl}) + b + 5'sd2 - $signed({2'b00, f_cwl});
      return (raw > t) ? $unsigned(raw) : $unsigned(t);
   endfunction

   assign burst      = (BL == 3'd0) ? 5'd4 : 5'd2;
   assign full       = fifo_count == CW'(DEPTH);
   assign req_rdy    = !full;
   assign push       = !request[2] && request[1:0] != 2'd0 && !full;
   assign hs         = cmd_valid && cmd_rdy;
   assign nx_ptr     = rd_ptr + PW'(1);
   assign head_vld   = fifo_count != '0;
   assign nxt_vld    = fifo_count > CW'(1);
   assign head_type  = type_mem[rd_ptr];
   assign nxt_type   = type_mem[nx_ptr];
   assign g_head     = (head_type == WR) ? g_wr_q : g_rd_q;
   assign gap_ok     = !col_seen || ({1'b0, el} + 6'd1 >= {1'b0, g_head});
   assign g_next     = gap_of(cmd_type == WR, nxt_type == WR,
                              tCCD, BL, CL, CWL);
   assign mrs_update = hs && cmd_type == MRS;

   always_ff @(posedge CK_t) begin
      if (push) begin
         type_mem[wr_ptr] <= request[1:0];
         addr_mem[wr_ptr] <= phy_addr;
      end
   end

   always_ff @(posedge CK_t) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (hs)
            rd_ptr <= nx_ptr;
         if (push && !hs)
            fifo_count <= fifo_count + CW'(1);
         else if (hs && !push)
            fifo_count <= fifo_count - CW'(1);
      end
   end

   // el counts edges since the last column handshake, starting at 1.
   always_ff @(posedge CK_t) begin
      if (!reset_n) begin
         quiet    <= '0;
         el       <= '0;
         col_seen <= 1'b0;
         g_rd_q   <= '0;
         g_wr_q   <= '0;
      end else if (hs && cmd_type != MRS) begin
         quiet    <= ((cmd_type == RD) ? {2'b00, CL} : {2'b00, CWL}) + burst;
         el       <= 5'd1;
         col_seen <= 1'b1;
         g_rd_q   <= gap_of(cmd_type == WR, 1'b0, tCCD, BL, CL, CWL);
         g_wr_q   <= gap_of(cmd_type == WR, 1'b1, tCCD, BL, CL, CWL);
      end else begin
         if (quiet != '0)
            quiet <= quiet - 5'd1;
         if (col_seen && el != 5'd31)
            el <= el + 5'd1;
      end
   end

   always_ff @(posedge CK_t) begin
      if (!reset_n) begin
         state     <= IDLE;
         cmd_valid <= 1'b0;
         cmd_type  <= '0;
         cmd_addr  <= '0;
         tmod_cnt  <= '0;
      end else begin
         unique case (state)
            IDLE, WAIT: begin
               if (!head_vld)
                  state <= IDLE;
               else if (head_type == MRS)
                  state <= QUIET;
               else if (!gap_ok)
                  state <= WAIT;
               else if (busy)
                  state <= IDLE;
               else begin
                  state     <= OFFER;
                  cmd_valid <= 1'b1;
                  cmd_type  <= head_type;
                  cmd_addr  <= addr_mem[rd_ptr];
               end
            end
            OFFER: begin
               if (cmd_rdy) begin
                  cmd_valid <= 1'b0;
                  if (cmd_type == MRS) begin
                     state    <= TMOD;
                     tmod_cnt <= MW'(T_MOD);
                  end else if (!nxt_vld)
                     state <= IDLE;
                  else if (nxt_type == MRS)
                     state <= QUIET;
                  else if (g_next > 5'd1)
                     state <= WAIT;
                  else if (busy)
                     state <= IDLE;
                  else begin
                     state     <= OFFER;
                     cmd_valid <= 1'b1;
                     cmd_type  <= nxt_type;
                     cmd_addr  <= addr_mem[nx_ptr];
                  end
               end
            end
            QUIET: begin
               // MRS handshake lands on the edge where quiet hits 0.
               if (quiet <= 5'd2 && !busy) begin
                  state     <= OFFER;
                  cmd_valid <= 1'b1;
                  cmd_type  <= head_type;
                  cmd_addr  <= addr_mem[rd_ptr];
               end
            end
            TMOD: begin
               if (tmod_cnt <= MW'(1)) begin
                  state    <= IDLE;
                  tmod_cnt <= '0;
               end else
                  tmod_cnt <= tmod_cnt - MW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed self-checking bench for ddr_cmd_scheduler.
// Handshake edges are logged and compared against hand-computed spacing.
module tb_ddr_cmd_scheduler;

   localparam logic [2:0] Q_RD  = 3'd1;
   localparam logic [2:0] Q_WR  = 3'd2;
   localparam logic [2:0] Q_MRS = 3'd3;

   logic        CK_t = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  request = '0;
   logic [31:0] phy_addr = '0;
   logic        req_rdy;
   logic [2:0]  CL = 3'd5;
   logic [2:0]  CWL = 3'd4;
   logic [2:0]  BL = 3'd0;
   logic [2:0]  tCCD = 3'd4;
   logic        busy = 1'b0;
   logic        cmd_valid;
   logic [1:0]  cmd_type;
   logic [31:0] cmd_addr;
   logic        cmd_rdy = 1'b0;
   logic        mrs_update;
   logic [2:0]  fifo_count;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int          hs_edge [$];
   logic [1:0]  hs_type [$];
   logic [31:0] hs_addr [$];
   int          mrs_edge [$];

   ddr_cmd_scheduler dut (
      .CK_t(CK_t), .reset_n(reset_n), .request(request),
      .phy_addr(phy_addr), .req_rdy(req_rdy), .CL(CL), .CWL(CWL),
      .BL(BL), .tCCD(tCCD), .busy(busy), .cmd_valid(cmd_valid),
      .cmd_type(cmd_type), .cmd_addr(cmd_addr), .cmd_rdy(cmd_rdy),
      .mrs_update(mrs_update), .fifo_count(fifo_count)
   );

   always #5 CK_t = ~CK_t;

   always @(posedge CK_t) cyc = cyc + 1;

   // Values seen at a negedge belong to the handshake at the next posedge.
   always @(negedge CK_t) begin
      if (reset_n) begin
         if (cmd_valid && cmd_rdy) begin
            hs_edge.push_back(cyc + 1);
            hs_type.push_back(cmd_type);
            hs_addr.push_back(cmd_addr);
         end
         if (mrs_update)
            mrs_edge.push_back(cyc + 1);
      end
   end

   task automatic tick();
      @(posedge CK_t);
      #1;
   endtask

   task automatic push(input logic [2:0] t, input logic [31:0] a,
                       output int e);
      request  = t;
      phy_addr = a;
      tick();
      e = cyc;
      request = '0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      request = '0;
      cmd_rdy = 1'b0;
      busy    = 1'b0;
      tick();
      reset_n = 1'b1;
      hs_edge.delete();
      hs_type.delete();
      hs_addr.delete();
      mrs_edge.delete();
   endtask

   task automatic wait_hs(input int n, input int lim, input string nm);
      int k = 0;
      while (hs_edge.size() < n && k < lim) begin
         tick();
         k++;
      end
      n_cmp++;
      if (hs_edge.size() < n) begin
         n_err++;
         $display("FAIL %s_timeout: got %0d handshakes want %0d",
                  nm, hs_edge.size(), n);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge CK_t);
      n_cmp += 6;
      if (cmd_valid !== 1'b0) begin
         n_err++; $display("FAIL rst_valid: got %b want 0", cmd_valid);
      end
      if (cmd_type !== 2'd0) begin
         n_err++; $display("FAIL rst_type: got %0d want 0", cmd_type);
      end
      if (cmd_addr !== 32'd0) begin
         n_err++; $display("FAIL rst_addr: got %h want 0", cmd_addr);
      end
      if (mrs_update !== 1'b0) begin
         n_err++; $display("FAIL rst_mrs: got %b want 0", mrs_update);
      end
      if (fifo_count !== 3'd0) begin
         n_err++; $display("FAIL rst_count: got %0d want 0", fifo_count);
      end
      if (req_rdy !== 1'b1) begin
         n_err++; $display("FAIL rst_req_rdy: got %b want 1", req_rdy);
      end
   endtask

   task automatic test_latency();
      int e;
      do_reset();
      push(Q_RD, 32'h100, e);
      @(negedge CK_t);
      n_cmp += 2;
      if (cmd_valid !== 1'b0) begin
         n_err++; $display("FAIL lat_early: got %b want 0", cmd_valid);
      end
      if (fifo_count !== 3'd1) begin
         n_err++; $display("FAIL lat_count: got %0d want 1", fifo_count);
      end
      tick();
      @(negedge CK_t);
      n_cmp += 3;
      if (cmd_valid !== 1'b1) begin
         n_err++; $display("FAIL lat_valid: got %b want 1", cmd_valid);
      end
      if (cmd_type !== 2'd1) begin
         n_err++; $display("FAIL lat_type: got %0d want 1", cmd_type);
      end
      if (cmd_addr !== 32'h100) begin
         n_err++; $display("FAIL lat_addr: got %h want 100", cmd_addr);
      end
      tick();
      cmd_rdy = 1'b1;
      tick();
      cmd_rdy = 1'b0;
      @(negedge CK_t);
      n_cmp += 3;
      if (fifo_count !== 3'd0) begin
         n_err++; $display("FAIL lat_pop: got %0d want 0", fifo_count);
      end
      if (cmd_valid !== 1'b0) begin
         n_err++; $display("FAIL lat_drop: got %b want 0", cmd_valid);
      end
      if (hs_edge.size() != 1 || hs_edge[0] != e + 3) begin
         n_err++;
         $display("FAIL lat_hs_edge: got %0d want %0d",
                  (hs_edge.size() > 0) ? hs_edge[0] : -1, e + 3);
      end
   endtask

   task automatic test_busy();
      int e;
      do_reset();
      busy = 1'b1;
      push(Q_RD, 32'h200, e);
      tick();
      tick();
      @(negedge CK_t);
      n_cmp++;
      if (cmd_valid !== 1'b0) begin
         n_err++; $display("FAIL busy_block: got %b want 0", cmd_valid);
      end
      tick();
      busy = 1'b0;
      tick();
      @(negedge CK_t);
      n_cmp++;
      if (cmd_valid !== 1'b1) begin
         n_err++; $display("FAIL busy_release: got %b want 1", cmd_valid);
      end
      tick();
      busy = 1'b1;
      tick();
      @(negedge CK_t);
      n_cmp += 2;
      if (cmd_valid !== 1'b1) begin
         n_err++; $display("FAIL busy_hold: got %b want 1", cmd_valid);
      end
      if (cmd_addr !== 32'h200) begin
         n_err++; $display("FAIL busy_addr: got %h want 200", cmd_addr);
      end
      tick();
      busy = 1'b0;
      cmd_rdy = 1'b1;
      wait_hs(1, 20, "busy");
      cmd_rdy = 1'b0;
   endtask

   task automatic test_back_to_back_reads();
      int e1, e2;
      do_reset();
      tCCD = 3'd4;
      cmd_rdy = 1'b1;
      push(Q_RD, 32'hA1, e1);
      push(Q_RD, 32'hA2, e2);
      wait_hs(2, 40, "b2b");
      tick();
      tick();
      @(negedge CK_t);
      n_cmp += 4;
      if (hs_edge[0] != e1 + 2) begin
         n_err++; $display("FAIL b2b_first: got %0d want %0d",
                           hs_edge[0], e1 + 2);
      end
      if (hs_edge[1] - hs_edge[0] != 4) begin
         n_err++; $display("FAIL b2b_gap: got %0d want 4",
                           hs_edge[1] - hs_edge[0]);
      end
      if (hs_addr[1] !== 32'hA2) begin
         n_err++; $display("FAIL b2b_addr: got %h want a2", hs_addr[1]);
      end
      if (fifo_count !== 3'd0) begin
         n_err++; $display("FAIL b2b_count: got %0d want 0", fifo_count);
      end
      cmd_rdy = 1'b0;
   endtask

   task automatic test_tccd0_back_to_back();
      int e;
      do_reset();
      tCCD = 3'd0;
      for (int i = 0; i < 3; i++)
         push(Q_RD, 32'h300 + 32'(i), e);
      cmd_rdy = 1'b1;
      wait_hs(3, 30, "tccd0");
      cmd_rdy = 1'b0;
      n_cmp += 4;
      if (hs_edge[0] != e + 1) begin
         n_err++; $display("FAIL tccd0_first: got %0d want %0d",
                           hs_edge[0], e + 1);
      end
      if (hs_edge[1] - hs_edge[0] != 1) begin
         n_err++; $display("FAIL tccd0_gap1: got %0d want 1",
                           hs_edge[1] - hs_edge[0]);
      end
      if (hs_edge[2] - hs_edge[1] != 1) begin
         n_err++; $display("FAIL tccd0_gap2: got %0d want 1",
                           hs_edge[2] - hs_edge[1]);
      end
      if (hs_addr[2] !== 32'h302) begin
         n_err++; $display("FAIL tccd0_addr: got %h want 302", hs_addr[2]);
      end
      tCCD = 3'd4;
   endtask

   task automatic test_rd_wr_turnaround();
      int e;
      do_reset();
      CL = 3'd5; CWL = 3'd4; BL = 3'd0; tCCD = 3'd4;
      cmd_rdy = 1'b1;
      push(Q_RD, 32'h400, e);
      push(Q_WR, 32'h404, e);
      wait_hs(2, 40, "rd_wr");
      cmd_rdy = 1'b0;
      n_cmp += 2;
      if (hs_edge[1] - hs_edge[0] != 7) begin
         n_err++; $display("FAIL rd_wr_gap: got %0d want 7",
                           hs_edge[1] - hs_edge[0]);
      end
      if (hs_type[1] !== 2'd2) begin
         n_err++; $display("FAIL rd_wr_type: got %0d want 2", hs_type[1]);
      end
   endtask

   task automatic test_wr_rd_turnaround();
      int e, want;
      for (int i = 0; i < 2; i++) begin
         do_reset();
         CWL  = 3'd4;
         tCCD = 3'd4;
         BL   = (i == 0) ? 3'd0 : 3'd1;
         want = (i == 0) ? 12 : 10;
         cmd_rdy = 1'b1;
         push(Q_WR, 32'h500, e);
         push(Q_RD, 32'h504, e);
         wait_hs(2, 40, "wr_rd");
         cmd_rdy = 1'b0;
         n_cmp++;
         if (hs_edge[1] - hs_edge[0] != want) begin
            n_err++; $display("FAIL wr_rd_gap_bl%0d: got %0d want %0d",
                              i, hs_edge[1] - hs_edge[0], want);
         end
      end
      BL = 3'd0;
   endtask

   task automatic test_mrs_sequencing();
      int e;
      do_reset();
      CL = 3'd5; CWL = 3'd4; BL = 3'd0; tCCD = 3'd4;
      cmd_rdy = 1'b1;
      push(Q_WR, 32'h600, e);
      push(Q_MRS, 32'h0AB, e);
      push(Q_RD, 32'h608, e);
      wait_hs(3, 100, "mrs");
      tick();
      cmd_rdy = 1'b0;
      n_cmp += 6;
      if (hs_type[1] !== 2'd3 || hs_type[2] !== 2'd1) begin
         n_err++; $display("FAIL mrs_order: got %0d,%0d want 3,1",
                           hs_type[1], hs_type[2]);
      end
      if (hs_edge[1] - hs_edge[0] != 8) begin
         n_err++; $display("FAIL mrs_quiet: got %0d want 8",
                           hs_edge[1] - hs_edge[0]);
      end
      if (hs_edge[2] - hs_edge[1] < 24) begin
         n_err++; $display("FAIL mrs_tmod: got %0d want >=24",
                           hs_edge[2] - hs_edge[1]);
      end
      if (mrs_edge.size() != 1) begin
         n_err++; $display("FAIL mrs_pulse_len: got %0d want 1",
                           mrs_edge.size());
      end
      if (mrs_edge[0] != hs_edge[1]) begin
         n_err++; $display("FAIL mrs_pulse_edge: got %0d want %0d",
                           mrs_edge[0], hs_edge[1]);
      end
      if (hs_addr[1] !== 32'h0AB) begin
         n_err++; $display("FAIL mrs_addr: got %h want ab", hs_addr[1]);
      end
   endtask

   task automatic test_full_fifo();
      int e;
      do_reset();
      tCCD = 3'd1;
      for (int i = 0; i < 4; i++)
         push(Q_RD, 32'h1000 + 32'(i * 16), e);
      @(negedge CK_t);
      n_cmp += 2;
      if (req_rdy !== 1'b0) begin
         n_err++; $display("FAIL full_rdy: got %b want 0", req_rdy);
      end
      if (fifo_count !== 3'd4) begin
         n_err++; $display("FAIL full_count: got %0d want 4", fifo_count);
      end
      tick();
      push(Q_RD, 32'h2000, e);
      @(negedge CK_t);
      n_cmp += 2;
      if (fifo_count !== 3'd4) begin
         n_err++; $display("FAIL full_drop: got %0d want 4", fifo_count);
      end
      if (cmd_addr !== 32'h1000) begin
         n_err++; $display("FAIL full_head: got %h want 1000", cmd_addr);
      end
      tick();
      cmd_rdy = 1'b1;
      wait_hs(4, 30, "full");
      for (int i = 0; i < 4; i++) tick();
      cmd_rdy = 1'b0;
      @(negedge CK_t);
      n_cmp += 3;
      if (hs_edge.size() != 4) begin
         n_err++; $display("FAIL full_hs_count: got %0d want 4",
                           hs_edge.size());
      end
      if (hs_addr[3] !== 32'h1030) begin
         n_err++; $display("FAIL full_last: got %h want 1030", hs_addr[3]);
      end
      if (fifo_count !== 3'd0) begin
         n_err++; $display("FAIL full_empty: got %0d want 0", fifo_count);
      end
      tCCD = 3'd4;
   endtask

   task automatic test_reset_mid_offer();
      int e;
      do_reset();
      for (int i = 0; i < 3; i++)
         push(Q_RD, 32'h700 + 32'(i), e);
      @(negedge CK_t);
      n_cmp += 2;
      if (cmd_valid !== 1'b1) begin
         n_err++; $display("FAIL rmid_pre_valid: got %b want 1", cmd_valid);
      end
      if (fifo_count !== 3'd3) begin
         n_err++; $display("FAIL rmid_pre_count: got %0d want 3", fifo_count);
      end
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      @(negedge CK_t);
      n_cmp += 3;
      if (cmd_valid !== 1'b0) begin
         n_err++; $display("FAIL rmid_valid: got %b want 0", cmd_valid);
      end
      if (fifo_count !== 3'd0) begin
         n_err++; $display("FAIL rmid_count: got %0d want 0", fifo_count);
      end
      if (req_rdy !== 1'b1) begin
         n_err++; $display("FAIL rmid_rdy: got %b want 1", req_rdy);
      end
      for (int i = 0; i < 3; i++) tick();
      @(negedge CK_t);
      n_cmp++;
      if (cmd_valid !== 1'b0) begin
         n_err++; $display("FAIL rmid_stay: got %b want 0", cmd_valid);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_busy();
      test_back_to_back_reads();
      test_tccd0_back_to_back();
      test_rd_wr_turnaround();
      test_wr_rd_turnaround();
      test_mrs_sequencing();
      test_full_fifo();
      test_reset_mid_offer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
